inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
// PURPOSE
//  Sequences instruction-memory reads. Owns the PC, drives the memory byte address, and waits MEM_LAT cycles for read data.
//  Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
//  Sits between the PC/branch logic and the InstructionMem read port; branch redirects flush and restart it.
// PARAMETERS
//  RESET_PC     32'h0  byte address fetched first after reset
//  MEM_LAT      2      clk cycles from mem_dir change to stable mem_inst; >=1, must cover the memory's read delay
//  DEPTH_WORDS  1024   memory depth in 32-bit words; PC wraps modulo DEPTH_WORDS*4
//  BUF_DEPTH    2      fetch buffer entries, power of 2, >=1
// PORTS
//  clk          in   1   single clock, all state updates on posedge
//  rst_n        in   1   synchronous reset, active low
//  enable       in   1   1 = keep fetching; 0 = finish current fetch, then idle
//  mem_dir      out  32  byte address to instruction memory, word aligned
//  mem_inst     in   32  instruction word returned by memory
//  inst         out  32  instruction at FIFO head
//  inst_pc      out  32  byte address of inst
//  inst_valid   out  1   FIFO head valid
//  inst_ready   in   1   decode accepts head this cycle
//  redirect     in   1   branch/jump taken: flush and refetch
//  redirect_pc  in   32  new fetch byte address
//  fetch_busy   out  1   FSM not in IDLE
//  misalign_err out  1   sticky flag: a redirect target had [1:0]!=0
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge) forces:
//    pc=mem_dir=RESET_PC, FSM=IDLE, wait cnt=0, FIFO empty.
//    inst=0, inst_pc=0, inst_valid=0, fetch_busy=0, misalign_err=0. Reset overrides every other input.
//  - FSM states IDLE, WAIT, HOLD.
//    IDLE: mem_dir=pc. If enable, go to WAIT with cnt=0.
//    WAIT: cnt++ each cycle. At cnt==MEM_LAT-1:
//      if FIFO can push: push {pc,mem_inst}, pc+=4, mem_dir=pc+4, cnt=0; stay in WAIT if enable, else go to IDLE.
//      else: go to HOLD.
//    HOLD: mem_dir and pc held. Push as soon as FIFO can push, then continue as in the WAIT capture.
//  - "Can push" = not full, OR full with a pop in the same cycle (simultaneous push/pop when full is legal).
//  - Timing: enable sampled high at edge E -> first inst_valid=1 after edge E+MEM_LAT.
//    Sustained throughput is one word per MEM_LAT cycles.
//  - Deasserting enable mid-WAIT does not abort: the in-flight word is captured, then the FSM goes to IDLE.
//  - Pop occurs when inst_valid&&inst_ready. inst/inst_pc are registered FIFO outputs and are stable while inst_valid&&!inst_ready.
//  - Redirect (priority just below reset), at that posedge:
//    FIFO flushed (inst_valid=0 next cycle), in-flight fetch discarded.
//    pc=mem_dir={redirect_pc[31:2],2'b00} mod DEPTH_WORDS*4, cnt=0.
//    FSM goes to WAIT if enable, else IDLE. misalign_err is set if redirect_pc[1:0]!=0; it is cleared only by reset.
//    A pop in the same cycle is honoured (decode consumed it); the flush still applies.
//  - Wrap: pc=(DEPTH_WORDS-1)*4 increments to 0. Redirect targets >= range wrap modulo the range.
//  - fetch_busy = (FSM!=IDLE). Only one read is outstanding at a time.
// STRUCTURE
//  - Package fetch_pkg: FSM state enum, INST_W=32, WORD_BYTES=4, PC_INC=4, default widths.
//  - Sub-module fetch_buf: sync FIFO of {pc,inst}, BUF_DEPTH entries.
//    Has push, pop, sync flush, full/empty, and registered head outputs.
//  - Top holds the FSM, PC/wrap arithmetic, wait counter, redirect and error logic.
// TESTING
//  1. Reset, enable=1, ready=1, MEM_LAT=2, mem model returns word i = 32'hA000_0000+i:
//     inst_pc 0,4,8,... with inst A0000000, A0000001,... one every 2 cycles; first valid 2 cycles after enable.
//  2. inst_ready=0 for 10 cycles:
//     FIFO fills to 2, FSM enters HOLD with mem_dir=8; inst stays A0000000/pc 0.
//     On ready=1, stream resumes with no word lost or duplicated.
//  3. redirect=1, redirect_pc=32'h40 while 2 entries are buffered:
//     next cycle inst_valid=0; next valid has inst_pc=0x40. Redirect to 0x42 gives pc 0x40 and misalign_err=1 (sticky).
//  4. DEPTH_WORDS=4, free run: inst_pc sequence 0,4,8,C,0,4. redirect_pc=0x14 fetches pc 0x4.
//  5. enable dropped one cycle into WAIT: that word is delivered, then fetch_busy=0 and mem_dir holds next pc.
//  6. rst_n=0 mid-WAIT with full FIFO: after that edge, all outputs are at reset values and mem_dir=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its buffer.
package fetch_pkg;

  localparam int INST_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous fetch FIFO of {pc,inst}; entry 0 is the head, so head outputs come straight from flops.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  fetch_entry_t     entries [BUF_DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] wr_idx;
  logic             do_pop;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(BUF_DEPTH));
  assign do_pop  = pop && !empty;
  assign push_ok = push && (do_pop || !full);
  // A simultaneous pop shifts everything down, so the write lands one slot lower.
  assign wr_idx  = do_pop ? count - 1'b1 : count;
  assign head    = entries[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (do_pop) begin
        for (int unsigned i = 0; i + 1 < BUF_DEPTH; i++) entries[i] <= entries[i+1];
      end
      if (push_ok) entries[IDX_W'(wr_idx)] <= din;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, paces memory reads by MEM_LAT and feeds decode through fetch_buf.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          MEM_LAT     = 2,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          BUF_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] mem_dir,
  input  logic [31:0] mem_inst,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_busy,
  output logic        misalign_err
);

  localparam logic [ADDR_W-1:0] PC_RANGE = ADDR_W'(DEPTH_WORDS * WORD_BYTES);
  localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);

  fetch_state_e      state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] redirect_tgt;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              buf_full;
  logic              buf_empty;
  logic              pop;
  logic              can_push;
  logic              capture;
  logic              push;

  assign pop          = inst_valid && inst_ready;
  assign can_push     = !buf_full || pop;
  assign capture      = ((state == WAIT) && (cnt == CNT_LAST)) || (state == HOLD);
  assign push         = capture && can_push && !redirect;
  assign pc_next      = (pc + PC_INC) % PC_RANGE;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00} % PC_RANGE;
  assign push_entry   = '{pc: pc, inst: mem_inst};

  fetch_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .head  (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_valid = !buf_empty;
  assign mem_dir    = pc;
  assign fetch_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      pc    <= redirect_tgt;
      cnt   <= '0;
      state <= enable ? WAIT : IDLE;
      if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enable) state <= WAIT;
        end
        WAIT: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (can_push) begin
            pc    <= pc_next;
            cnt   <= '0;
            state <= enable ? WAIT : IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (can_push) begin
            pc    <= pc_next;
            cnt   <= '0;
            state <= enable ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
